trj_reg_tap: RTL and testbench

Upstream feed stage for the IRT-1 software-triggered trigger. Snoops the GPR writeback ports at commit, tracks a two-value write sequence to one architectural register, and drives the two 64-bit match vectors, `regBits1` and `regBits0`, into the trigger stage.

- `regBits1_o` has a 1 in every bit where the captured value equals `KEY`.
- `regBits0_o` has a 1 in every bit where the captured value differs from `KEY`.

The trigger stage fires only when `regBits1_o` is all ones and `regBits0_o` is all zeros.

---
 rtl/trj_pkg.sv | 32 +++
 rtl/trj_wb_sel.sv | 36 +++
 rtl/trj_reg_tap.sv | 123 ++++++++++++
 tb/tb_trj_reg_tap.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trj_pkg.sv
// Shared types and defaults for the register-tap trigger feed.
package trj_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [XLEN-1:0] DEF_ARM_VALUE  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [XLEN-1:0] DEF_KEY        = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam int unsigned     DEF_ARM_WINDOW = 16;

    // Vector values that keep the downstream NOR low.
    localparam logic [XLEN-1:0] RST_BITS1 = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] RST_BITS0 = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MATCHED = 2'd2
    } trj_state_e;

    // Ones where the value agrees with the key.
    function automatic logic [XLEN-1:0] match_ones(input logic [XLEN-1:0] value,
                                                   input logic [XLEN-1:0] key);
        return ~(value ^ key);
    endfunction

    // Ones where the value disagrees with the key.
    function automatic logic [XLEN-1:0] match_zeros(input logic [XLEN-1:0] value,
                                                    input logic [XLEN-1:0] key);
        return value ^ key;
    endfunction

endpackage

// File: rtl/trj_wb_sel.sv
// Writeback-port snooper: picks the tap-register write that is latest in
// program order (highest port index) among all commit ports this cycle.
module trj_wb_sel
    import trj_pkg::*;
#(
    parameter int unsigned NR_WB_PORTS = 2,
    parameter logic [4:0]  TAP_REG     = 5'd10
) (
    input  logic [NR_WB_PORTS-1:0]           we_gpr,
    input  logic [NR_WB_PORTS-1:0][4:0]      waddr,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0] wdata,
    output logic                             hit,
    output logic [XLEN-1:0]                  hit_data
);

    logic [NR_WB_PORTS-1:0] port_hit;

    // Per-port hit; x0 is hard-wired zero so a tap on it can never fire.
    generate
        for (genvar gi = 0; gi < NR_WB_PORTS; gi++) begin : g_port
            assign port_hit[gi] = we_gpr[gi] && (waddr[gi] == TAP_REG) && (TAP_REG != 5'd0);
        end
    endgenerate

    // Ascending scan so the highest-index hitting port overrides lower ones.
    always_comb begin
        hit      = |port_hit;
        hit_data = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (port_hit[p]) begin
                hit_data = wdata[p];
            end
        end
    end

endmodule

// File: rtl/trj_reg_tap.sv
// Register tap feeding the software-triggered trigger stage. Watches commits
// to one GPR for an arm value followed by a key value and presents the
// bitwise key compare as two match vectors.
// Build option: define TRJ_TAP_HOLD_EN to make the MATCHED state sticky
// until reset; otherwise MATCHED is left on the next tap write.
module trj_reg_tap
    import trj_pkg::*;
#(
    parameter int unsigned     NR_WB_PORTS = 2,
    parameter logic [4:0]      TAP_REG     = 5'd10,
    parameter logic [XLEN-1:0] ARM_VALUE   = DEF_ARM_VALUE,
    parameter logic [XLEN-1:0] KEY         = DEF_KEY,
    parameter int unsigned     ARM_WINDOW  = DEF_ARM_WINDOW
) (
    input  logic                             clk,
    input  logic                             rst_ni,
    input  logic [NR_WB_PORTS-1:0]           we_gpr_i,
    input  logic [NR_WB_PORTS-1:0][4:0]      waddr_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0] wdata_i,
    output logic [XLEN-1:0]                  regBits1_o,
    output logic [XLEN-1:0]                  regBits0_o,
    output logic                             armed_o
);

    localparam int unsigned     CNT_W    = (ARM_WINDOW > 2) ? $clog2(ARM_WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ARM_WINDOW - 1);

    logic            hit;
    logic [XLEN-1:0] hit_data;

    trj_state_e      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] bits1_reg;
    logic [XLEN-1:0] bits0_reg;
    logic            armed_reg;

    trj_wb_sel #(
        .NR_WB_PORTS (NR_WB_PORTS),
        .TAP_REG     (TAP_REG)
    ) u_wb_sel (
        .we_gpr   (we_gpr_i),
        .waddr    (waddr_i),
        .wdata    (wdata_i),
        .hit      (hit),
        .hit_data (hit_data)
    );

    // Sequence FSM with window counter and registered compare vectors.
    // A tap hit is always checked before window expiry, so a write in the
    // cycle the counter reads zero is still honoured.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bits1_reg <= RST_BITS1;
            bits0_reg <= RST_BITS0;
            armed_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hit && (hit_data == ARM_VALUE)) begin
                        state_reg <= ST_ARMED;
                        cnt_reg   <= CNT_LOAD;
                        armed_reg <= 1'b1;
                    end
                end

                ST_ARMED: begin
                    if (hit) begin
                        bits1_reg <= match_ones(hit_data, KEY);
                        bits0_reg <= match_zeros(hit_data, KEY);
                        if (hit_data == KEY) begin
                            state_reg <= ST_MATCHED;
                            cnt_reg   <= '0;
                            armed_reg <= 1'b0;
                        end else if (hit_data == ARM_VALUE) begin
                            cnt_reg   <= CNT_LOAD;
                        end else begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            armed_reg <= 1'b0;
                        end
                    end else if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        armed_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                ST_MATCHED: begin
`ifdef TRJ_TAP_HOLD_EN
                    // Sticky: vectors hold the key compare until reset.
`else
                    if (hit) begin
                        bits1_reg <= RST_BITS1;
                        bits0_reg <= RST_BITS0;
                        if (hit_data == ARM_VALUE) begin
                            state_reg <= ST_ARMED;
                            cnt_reg   <= CNT_LOAD;
                            armed_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            armed_reg <= 1'b0;
                        end
                    end
`endif
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    armed_reg <= 1'b0;
                end
            endcase
        end
    end

    assign regBits1_o = bits1_reg;
    assign regBits0_o = bits0_reg;
    assign armed_o    = armed_reg;

endmodule

// File: tb/tb_trj_reg_tap.sv
// Scoreboard bench for trj_reg_tap. Stimulus queues expected outputs keyed
// by cycle number; a negedge monitor pops and compares them. A one-register
// model of the downstream trigger stage is included.
// Expectations for the MATCHED exit follow TRJ_TAP_HOLD_EN when defined.
module tb_trj_reg_tap;

    localparam logic [63:0] ARM     = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] KEY     = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZEROS   = 64'h0;
    localparam logic [63:0] P1_B1   = 64'h5A5A_A5A5_F0F0_0F0E;   // ~(1 ^ KEY)
    localparam logic [63:0] P1_B0   = 64'hA5A5_5A5A_0F0F_F0F1;   //  (1 ^ KEY)
    localparam logic [63:0] AV_B1   = 64'h84F7_1B4A_F0F0_0F0E;   // ~(ARM ^ KEY)
    localparam logic [63:0] AV_B0   = 64'h7B08_E4B5_0F0F_F0F1;   //  (ARM ^ KEY)
    localparam logic [63:0] NEAR    = 64'hA5A5_5A5A_0F0F_F0F1;   // KEY ^ 1

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       we_gpr;
    logic [1:0][4:0]  waddr;
    logic [1:0][63:0] wdata;
    logic [63:0]      bits1;
    logic [63:0]      bits0;
    logic             armed;
    logic             trig;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int          at;
        logic        cv;
        logic [63:0] b1;
        logic [63:0] b0;
        logic        ca;
        logic        a;
        logic        ct;
        logic        t;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    trj_reg_tap dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .we_gpr_i   (we_gpr),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .regBits1_o (bits1),
        .regBits0_o (bits0),
        .armed_o    (armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Downstream trigger stage: one register on the NOR-style match.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) trig <= 1'b0;
        else         trig <= (&bits1) && !(|bits0);
    end

    task automatic expect_at(input int at, input string nm,
                             input logic cv, input logic [63:0] b1, input logic [63:0] b0,
                             input logic ca, input logic a,
                             input logic ct, input logic t);
        exp_t e;
        e.at = at; e.cv = cv; e.b1 = b1; e.b0 = b0;
        e.ca = ca; e.a = a; e.ct = ct; e.t = t;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic chk(input string nm, input string fld,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cyc %0d %s.%s: got %h expected %h", cyc, nm, fld, act, req);
        end
    endtask

    // Monitor: compare every queued expectation due this cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                if (e.at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: due at cyc %0d but reached at cyc %0d", nm, e.at, cyc);
                end else begin
                    if (e.cv) begin
                        chk(nm, "regBits1", bits1, e.b1);
                        chk(nm, "regBits0", bits0, e.b0);
                    end
                    if (e.ca) chk(nm, "armed", {63'b0, armed}, {63'b0, e.a});
                    if (e.ct) chk(nm, "trigger", {63'b0, trig}, {63'b0, e.t});
                    $display("[cyc %0d] %s b1=%h b0=%h armed=%b trig=%b",
                             cyc, nm, bits1, bits0, armed, trig);
                end
            end
        end
    end

    // Move to the next negedge and clear all write ports.
    task automatic nxt();
        @(negedge clk);
        we_gpr = '0;
        waddr  = '0;
        wdata  = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
        we_gpr[p] = 1'b1;
        waddr[p]  = a;
        wdata[p]  = d;
    endtask

    task automatic rst_pulse();
        nxt();
        rst_ni = 1'b0;
        nxt();
        rst_ni = 1'b1;
    endtask

    initial begin
        int t0;
        we_gpr = '0;
        waddr  = '0;
        wdata  = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values while held and after release.
        expect_at(cyc + 1, "reset_held", 1, ZEROS, ONES, 1, 0, 1, 0);
        nxt();
        rst_ni = 1'b1;
        expect_at(cyc + 1, "reset_rel", 1, ZEROS, ONES, 1, 0, 1, 0);

        // Arm then key, trigger two cycles after the key write.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        expect_at(t0 + 1, "arm_armed", 1, ZEROS, ONES, 1, 1, 0, 0);
        expect_at(t0 + 3, "arm_hold",  0, ZEROS, ZEROS, 1, 1, 0, 0);
        expect_at(t0 + 4, "key_vec",   1, ONES, ZEROS, 1, 0, 1, 0);
        expect_at(t0 + 5, "key_trig",  1, ONES, ZEROS, 0, 0, 1, 1);
        nxt();
        nxt();
        nxt();
        wr(1, 5'd10, KEY);
        nxt();
        nxt();
        wr(0, 5'd10, 64'h0);
`ifdef TRJ_TAP_HOLD_EN
        expect_at(t0 + 6, "matched_exit", 1, ONES, ZEROS, 1, 0, 0, 0);
        expect_at(t0 + 7, "matched_trig", 0, ZEROS, ZEROS, 0, 0, 1, 1);
`else
        expect_at(t0 + 6, "matched_exit", 1, ZEROS, ONES, 1, 0, 0, 0);
        expect_at(t0 + 7, "matched_trig", 0, ZEROS, ZEROS, 0, 0, 1, 0);
`endif
        nxt();
        nxt();
        rst_pulse();

        // Window expiry, then a late key leaves the vectors at reset.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        expect_at(t0 + 1,  "win_start",  0, ZEROS, ZEROS, 1, 1, 0, 0);
        expect_at(t0 + 16, "win_last",   0, ZEROS, ZEROS, 1, 1, 0, 0);
        expect_at(t0 + 17, "win_expire", 1, ZEROS, ONES, 1, 0, 0, 0);
        expect_at(t0 + 21, "late_key",   1, ZEROS, ONES, 1, 0, 0, 0);
        expect_at(t0 + 22, "late_trig",  0, ZEROS, ZEROS, 0, 0, 1, 0);
        repeat (20) nxt();
        wr(0, 5'd10, KEY);
        nxt();
        nxt();

        // Key in the very cycle the counter reaches zero is honoured.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        expect_at(t0 + 16, "edge_armed", 0, ZEROS, ZEROS, 1, 1, 0, 0);
        expect_at(t0 + 17, "edge_key",   1, ONES, ZEROS, 1, 0, 0, 0);
        repeat (16) nxt();
        wr(1, 5'd10, KEY);
        nxt();
        rst_pulse();

        // Re-arm while armed reloads the window and captures the compare.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        repeat (10) nxt();
        wr(0, 5'd10, ARM);
        expect_at(t0 + 11, "rearm_cap",  1, AV_B1, AV_B0, 1, 1, 0, 0);
        expect_at(t0 + 26, "rearm_last", 0, ZEROS, ZEROS, 1, 1, 0, 0);
        expect_at(t0 + 27, "rearm_exp",  1, AV_B1, AV_B0, 1, 0, 0, 0);
        repeat (18) nxt();
        rst_pulse();

        // Port priority: port1 (value 1) overrides port0 (KEY).
        nxt();
        t0 = cyc;
        wr(1, 5'd10, ARM);
        nxt();
        wr(0, 5'd10, KEY);
        wr(1, 5'd10, 64'h1);
        expect_at(t0 + 2, "prio_vec", 1, P1_B1, P1_B0, 1, 0, 0, 0);
        nxt();
        wr(0, 5'd10, KEY);
        expect_at(t0 + 3, "prio_idle", 1, P1_B1, P1_B0, 1, 0, 1, 0);
        nxt();
        nxt();
        rst_pulse();

        // Higher port writing another register does not mask port0.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        nxt();
        wr(0, 5'd10, KEY);
        wr(1, 5'd11, 64'h1);
        expect_at(t0 + 2, "other_reg", 1, ONES, ZEROS, 1, 0, 0, 0);
        nxt();
        rst_pulse();

        // Near-miss key, then arm value to x0 and to a neighbour register.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        nxt();
        wr(0, 5'd10, NEAR);
        expect_at(t0 + 2, "near_vec", 1, ONES ^ 64'h1, 64'h1, 1, 0, 0, 0);
        nxt();
        wr(0, 5'd0, ARM);
        wr(1, 5'd0, ARM);
        expect_at(t0 + 3, "x0_arm", 1, ONES ^ 64'h1, 64'h1, 1, 0, 1, 0);
        nxt();
        wr(1, 5'd11, ARM);
        expect_at(t0 + 4, "a1_arm", 0, ZEROS, ZEROS, 1, 0, 0, 0);
        nxt();
        nxt();
        rst_pulse();

        // Asynchronous reset while armed with counter at 9.
        nxt();
        t0 = cyc;
        wr(0, 5'd10, ARM);
        expect_at(t0 + 6, "mid_armed", 0, ZEROS, ZEROS, 1, 1, 0, 0);
        repeat (6) nxt();
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        expect_at(cyc, "mid_reset", 1, ZEROS, ONES, 1, 0, 1, 0);
        nxt();
        rst_ni = 1'b1;
        expect_at(cyc + 1, "mid_after", 1, ZEROS, ONES, 1, 0, 0, 0);
        repeat (3) nxt();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cyc %0d never checked", sb_name.pop_front(), e.at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
